// File: rtl/tmds_rx_align_decode_if.sv
// Receive-side TMDS channel bundle between the deserializer/capture side and
// the aligner/decoder.
//   din      : 10-bit symbol from the 1:10 deserializer, bit0 received first
//   bitslip  : one-cycle request to rotate the deserializer word boundary
//   slip_cnt : bitslips issued since the last lock (0..9, wraps)
//   aligned  : word alignment held
//   de/ctl/data : decoded channel outputs
// master = deserializer/capture side, slave = tmds_rx_align_decode.
interface tmds_rx_align_decode_if;
   logic [9:0] din;
   logic       bitslip;
   logic [3:0] slip_cnt;
   logic       aligned;
   logic       de;
   logic [1:0] ctl;
   logic [7:0] data;

   modport master (
      output din,
      input  bitslip, slip_cnt, aligned, de, ctl, data
   );

   modport slave (
      input  din,
      output bitslip, slip_cnt, aligned, de, ctl, data
   );
endinterface

// File: rtl/tmds_rx_align_decode.sv
// One TMDS receive channel in the pixel-clock domain: hunts for word
// alignment on runs of identical control tokens, steps the deserializer with
// bitslip pulses until found, decodes symbols to DE/CTL/data, and drops
// alignment if no qualifying control run is seen for LOSS_WIN cycles.
// Ports:
//   clk_p     : pixel clock, rising edge
//   ext_reset : asynchronous, active-low reset
//   rx        : channel bundle (slave side), see tmds_rx_align_decode_if
// Pipeline: din -> s1 (register) -> decode/gate -> output registers,
// two clk_p cycles from din to de/ctl/data.
//
// state  | meaning
// SEARCH | counting a search window, waiting for a control run
// SLIP   | single cycle, bitslip pulse issued
// WAIT   | deserializer settling after a slip, tokens ignored
// LOCKED | aligned, watching for loss of control runs
module tmds_rx_align_decode #(
   parameter int CTL_RUN    = 8,
   parameter int SEARCH_WIN = 2048,
   parameter int SLIP_WAIT  = 16,
   parameter int LOSS_WIN   = 4096
) (
   input logic                   clk_p,
   input logic                   ext_reset,
   tmds_rx_align_decode_if.slave rx
);
   localparam int RW = $clog2(CTL_RUN) + 1;
   localparam int WW = $clog2(SEARCH_WIN) + 1;
   localparam int SW = $clog2(SLIP_WAIT) + 1;
   localparam int LW = $clog2(LOSS_WIN) + 1;

   localparam logic [RW-1:0] RUN_MAX   = RW'(CTL_RUN);
   localparam logic [RW-1:0] RUN_LAST  = RW'(CTL_RUN - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_WIN - 1);
   localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WIN - 1);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t        state_q,    state_d;
   logic [9:0]    s1_q,       s1_d;
   logic [RW-1:0] run_cnt_q,  run_cnt_d;
   logic [1:0]    prev_tok_q, prev_tok_d;
   logic [WW-1:0] win_cnt_q,  win_cnt_d;
   logic [SW-1:0] wait_cnt_q, wait_cnt_d;
   logic [LW-1:0] loss_cnt_q, loss_cnt_d;
   logic [3:0]    slip_cnt_q, slip_cnt_d;
   logic          bitslip_q,  bitslip_d;
   logic          aligned_q,  aligned_d;
   logic          de_q,       de_d;
   logic [1:0]    ctl_q,      ctl_d;
   logic [7:0]    data_q,     data_d;

   logic          is_tok;
   logic [1:0]    tok_val;
   logic          tok_match;
   logic          run_hit;
   logic [7:0]    q_sym;
   logic [7:0]    dec;

   assign s1_d = rx.din;

   // Token classification and data decode of the stage-1 symbol.
   always_comb begin
      is_tok  = 1'b1;
      tok_val = 2'd0;
      case (s1_q)
         TOK_00:  tok_val = 2'd0;
         TOK_01:  tok_val = 2'd1;
         TOK_10:  tok_val = 2'd2;
         TOK_11:  tok_val = 2'd3;
         default: is_tok  = 1'b0;
      endcase

      q_sym  = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
      dec    = '0;
      dec[0] = q_sym[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = s1_q[8] ? (q_sym[i] ^ q_sym[i-1]) : ~(q_sym[i] ^ q_sym[i-1]);
      end
   end

   // Run tracking. run_cnt_q == 0 means no previous token to compare against,
   // so prev_tok_q needs no separate valid bit. Saturating at CTL_RUN means a
   // long run produces exactly one run_hit.
   always_comb begin
      tok_match  = is_tok && (run_cnt_q != '0) && (tok_val == prev_tok_q);
      run_hit    = tok_match && (run_cnt_q == RUN_LAST);
      run_cnt_d  = run_cnt_q;
      prev_tok_d = prev_tok_q;
      if (state_q == ST_SLIP || state_q == ST_WAIT) begin
         run_cnt_d = '0;
      end else if (!is_tok) begin
         run_cnt_d = '0;
      end else begin
         prev_tok_d = tok_val;
         if (!tok_match) begin
            run_cnt_d = RW'(1);
         end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + RW'(1);
         end
      end
   end

   // Next state. Lock is checked before window expiry so a run_hit on the
   // last window cycle locks instead of slipping.
   always_comb begin
      state_d    = state_q;
      win_cnt_d  = '0;
      wait_cnt_d = '0;
      loss_cnt_d = '0;
      slip_cnt_d = slip_cnt_q;
      bitslip_d  = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (run_hit) begin
               state_d    = ST_LOCKED;
               slip_cnt_d = 4'd0;
            end else if (win_cnt_q == WIN_LAST) begin
               state_d    = ST_SLIP;
               bitslip_d  = 1'b1;
               slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
            end else begin
               win_cnt_d = win_cnt_q + WW'(1);
            end
         end
         ST_SLIP: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_SEARCH;
            end else begin
               wait_cnt_d = wait_cnt_q + SW'(1);
            end
         end
         ST_LOCKED: begin
            if (run_hit) begin
               loss_cnt_d = '0;
            end else if (loss_cnt_q == LOSS_LAST) begin
               state_d = ST_SEARCH;
            end else begin
               loss_cnt_d = loss_cnt_q + LW'(1);
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase
   end

   // Outputs are gated by the next-cycle aligned value so that de/ctl/data
   // and aligned change in the same cycle.
   always_comb begin
      aligned_d = (state_d == ST_LOCKED);
      de_d      = 1'b0;
      ctl_d     = 2'd0;
      data_d    = 8'd0;
      if (aligned_d) begin
         if (is_tok) begin
            ctl_d = tok_val;
         end else begin
            de_d   = 1'b1;
            ctl_d  = ctl_q;
            data_d = dec;
         end
      end
   end

   always_ff @(posedge clk_p or negedge ext_reset) begin
      if (!ext_reset) begin
         state_q    <= ST_SEARCH;
         s1_q       <= '0;
         run_cnt_q  <= '0;
         prev_tok_q <= '0;
         win_cnt_q  <= '0;
         wait_cnt_q <= '0;
         loss_cnt_q <= '0;
         slip_cnt_q <= '0;
         bitslip_q  <= 1'b0;
         aligned_q  <= 1'b0;
         de_q       <= 1'b0;
         ctl_q      <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         run_cnt_q  <= run_cnt_d;
         prev_tok_q <= prev_tok_d;
         win_cnt_q  <= win_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         slip_cnt_q <= slip_cnt_d;
         bitslip_q  <= bitslip_d;
         aligned_q  <= aligned_d;
         de_q       <= de_d;
         ctl_q      <= ctl_d;
         data_q     <= data_d;
      end
   end

   assign rx.bitslip  = bitslip_q;
   assign rx.slip_cnt = slip_cnt_q;
   assign rx.aligned  = aligned_q;
   assign rx.de       = de_q;
   assign rx.ctl      = ctl_q;
   assign rx.data     = data_q;

endmodule
